dispense_sequencer: RTL and testbench
=====================================

DISPENSE_SEQUENCER -- requirements
Module: dispense_sequencer

Interface
REQ-001 SHALL have parameter MOTOR_SECS, default 2: seconds the motor is driven per attempt (1..15).
REQ-002 SHALL have parameter CONFIRM_SECS, default 5: seconds allowed for pill-drop confirmation (1..15).
REQ-003 SHALL have parameter MAX_RETRY, default 2: extra drive attempts before alarm (0..3).
REQ-004 SHALL have port CLOCK_50  in  1  single system clock; all logic on its rising edge.
REQ-005 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have port sec_tick  in  1  one-cycle pulse per second.
REQ-007 SHALL have port req_morning / req_afternoon / req_evening  in  1 each  one-cycle dose-time pulses.
REQ-008 SHALL have port manual_req  in  1  one-cycle manual dose request.
REQ-009 SHALL have port manual_slot  in  2  slot for manual_req: 0 morning, 1 afternoon, 2 evening.
REQ-010 SHALL have port pill_sensor  in  1  high while a pill is detected; already synchronised.
REQ-011 SHALL have port ack  in  1  user acknowledge; clears alarm and missed flags.
REQ-012 SHALL have port motor_en  out  1  dispenser motor drive.
REQ-013 SHALL have port slot_sel  out  2  compartment currently served.
REQ-014 SHALL have port busy  out  1  high in any state except IDLE.
REQ-015 SHALL have port done_pulse  out  1  one-cycle pulse on a confirmed dispense.
REQ-016 SHALL have port alarm  out  1  high in ALARM.
REQ-017 SHALL have port pending  out  3  queued requests, bit index equals slot.
REQ-018 SHALL have port missed  out  3  sticky per-slot failed-dose flags.

Function
REQ-019 SHALL implement FSM states IDLE, DRIVE, CONFIRM, ALARM; all outputs registered.
REQ-020 SHALL set pending[s] on a request for slot s in any state; requests for an already-pending slot are merged.
REQ-021 SHALL ignore manual_req when manual_slot==3.
REQ-022 SHALL, in IDLE with pending!=0, grant the lowest-index pending slot: latch slot_sel, clear its pending bit, clear retry count and pill_seen, enter DRIVE on the same edge.
REQ-023 SHALL give set priority when a request and a grant hit the same pending bit in one cycle; the bit stays 1.
REQ-024 SHALL assert motor_en only in DRIVE, from the first DRIVE cycle until the edge after the MOTOR_SECS-th sec_tick, then enter CONFIRM.
REQ-025 SHALL set pill_seen whenever pill_sensor==1 in DRIVE or CONFIRM.
REQ-026 SHALL, in CONFIRM with pill_seen==1, go to IDLE and assert done_pulse for exactly one cycle, at most 2 cycles after pill_sensor rises.
REQ-027 SHALL, on the CONFIRM_SECS-th sec_tick in CONFIRM without pill_seen, increment retry and re-enter DRIVE if retry<MAX_RETRY, else enter ALARM and set missed[slot_sel].
REQ-028 SHALL restart the second timer at 0 on every entry to DRIVE or CONFIRM; a sec_tick on the entry cycle is not counted.
REQ-029 SHALL hold ALARM, with motor_en=0 and pending still accumulating, until ack==1, then go to IDLE and clear missed.
REQ-030 SHALL ignore ack outside ALARM.

Reset
REQ-031 SHALL, while reset==1, force IDLE with motor_en=0, slot_sel=0, busy=0, done_pulse=0, alarm=0, pending=0, missed=0, and timer, retry and pill_seen at 0.
REQ-032 SHALL drop motor_en on the first reset edge when reset is asserted mid-DRIVE, and discard all queued requests.

Structure
REQ-033 SHALL take the state encoding and the SLOT_MORNING=0 / SLOT_AFTERNOON=1 / SLOT_EVENING=2 constants from shared package dispense_pkg.
REQ-034 SHALL use one sub-module, sec_timer: a 4-bit sec_tick counter with clear input and terminal-count output.

Verification (MOTOR_SECS=2, CONFIRM_SECS=5, MAX_RETRY=2)
REQ-035 SHALL cover: req_morning, then pill_sensor high 1 tick after CONFIRM entry -> motor_en high for 2 ticks, slot_sel=0, one done_pulse, busy falls.
REQ-036 SHALL cover: req_evening and manual_req(slot 1) in the same cycle -> pending=3'b110; slot 1 served, then slot 2.
REQ-037 SHALL cover: no pill_sensor ever -> 3 DRIVE bursts of 2 ticks each, then alarm=1 and missed=3'b001; ack -> alarm=0, missed=0, IDLE.
REQ-038 SHALL cover: req_morning during slot-0 DRIVE -> pending[0]=1 and slot 0 served again after done_pulse.
REQ-039 SHALL cover: reset pulse mid-DRIVE with pending=3'b110 -> motor_en=0 next cycle and pending=0.
REQ-040 SHALL cover: manual_req with manual_slot=3 -> pending unchanged and busy stays 0.

Source files
------------

// File: rtl/dispense_pkg.sv
// Shared state encoding, slot constants and slot helpers for the pill dispenser.
package dispense_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DRIVE   = 2'd1,
    CONFIRM = 2'd2,
    ALARM   = 2'd3
  } state_t;

  localparam logic [1:0] SLOT_MORNING   = 2'd0;
  localparam logic [1:0] SLOT_AFTERNOON = 2'd1;
  localparam logic [1:0] SLOT_EVENING   = 2'd2;

  // Lowest-index pending slot; only meaningful when p is non-zero.
  function automatic logic [1:0] lowest_slot(input logic [2:0] p);
    logic [1:0] s;
    if (p[0])      s = SLOT_MORNING;
    else if (p[1]) s = SLOT_AFTERNOON;
    else           s = SLOT_EVENING;
    return s;
  endfunction

  function automatic logic [2:0] slot_mask(input logic [1:0] s);
    logic [2:0] m;
    case (s)
      SLOT_MORNING:   m = 3'b001;
      SLOT_AFTERNOON: m = 3'b010;
      SLOT_EVENING:   m = 3'b100;
      default:        m = 3'b000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/sec_timer.sv
// Counts sec_tick pulses from zero; tc flags the tick that reaches the limit.
module sec_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       tick,
  input  logic [3:0] limit,
  output logic       tc
);

  logic [3:0] count_q, count_d;

  // Clear wins over a coincident tick so the entry-cycle tick is dropped.
  always_comb begin
    count_d = count_q;
    if (clr)       count_d = 4'd0;
    else if (tick) count_d = count_q + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) count_q <= 4'd0;
    else     count_q <= count_d;
  end

  assign tc = tick && (count_q == (limit - 4'd1));

endmodule

// File: rtl/dispense_sequencer.sv
// Pill dispenser sequencer: queues dose requests per slot, drives the motor,
// waits for drop confirmation, retries and raises a sticky alarm on failure.
module dispense_sequencer
  import dispense_pkg::*;
#(
  parameter int MOTOR_SECS   = 2,
  parameter int CONFIRM_SECS = 5,
  parameter int MAX_RETRY    = 2
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       sec_tick,
  input  logic       req_morning,
  input  logic       req_afternoon,
  input  logic       req_evening,
  input  logic       manual_req,
  input  logic [1:0] manual_slot,
  input  logic       pill_sensor,
  input  logic       ack,
  output logic       motor_en,
  output logic [1:0] slot_sel,
  output logic       busy,
  output logic       done_pulse,
  output logic       alarm,
  output logic [2:0] pending,
  output logic [2:0] missed
);

  localparam logic [3:0] MOTOR_LIM   = 4'(MOTOR_SECS);
  localparam logic [3:0] CONFIRM_LIM = 4'(CONFIRM_SECS);
  localparam logic [1:0] RETRY_LIM   = 2'(MAX_RETRY);

  state_t     state_q;
  logic [1:0] slot_q;
  logic [1:0] retry_q;
  logic       pill_seen_q;
  logic       motor_q;
  logic       busy_q;
  logic       done_q;
  logic       alarm_q;
  logic [2:0] pending_q, pending_d;
  logic [2:0] missed_q;

  logic [2:0] req_mask;
  logic [2:0] grant_mask;
  logic [3:0] timer_limit;
  logic       timer_clr;
  logic       timer_tc;

  always_comb begin
    req_mask = {req_evening, req_afternoon, req_morning};
    if (manual_req) req_mask = req_mask | slot_mask(manual_slot);
    grant_mask = 3'b000;
    if (state_q == IDLE && pending_q != 3'b000) grant_mask = slot_mask(lowest_slot(pending_q));
    // New requests are OR-ed after the grant clear so a colliding set survives.
    pending_d = (pending_q & ~grant_mask) | req_mask;
  end

  // The timer restarts on every DRIVE/CONFIRM entry: held clear when idle or
  // alarmed, and cleared on the terminal tick that moves between the two.
  assign timer_limit = (state_q == DRIVE) ? MOTOR_LIM : CONFIRM_LIM;
  assign timer_clr   = (state_q == IDLE) || (state_q == ALARM) || timer_tc;

  sec_timer u_sec_timer (
    .clk   (CLOCK_50),
    .rst   (reset),
    .clr   (timer_clr),
    .tick  (sec_tick),
    .limit (timer_limit),
    .tc    (timer_tc)
  );

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q     <= IDLE;
      slot_q      <= SLOT_MORNING;
      retry_q     <= 2'd0;
      pill_seen_q <= 1'b0;
      motor_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      alarm_q     <= 1'b0;
      pending_q   <= 3'b000;
      missed_q    <= 3'b000;
    end else begin
      done_q    <= 1'b0;
      pending_q <= pending_d;
      if ((state_q == DRIVE || state_q == CONFIRM) && pill_sensor) pill_seen_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (pending_q != 3'b000) begin
            slot_q      <= lowest_slot(pending_q);
            retry_q     <= 2'd0;
            pill_seen_q <= 1'b0;
            motor_q     <= 1'b1;
            busy_q      <= 1'b1;
            state_q     <= DRIVE;
          end
        end
        DRIVE: begin
          if (timer_tc) begin
            motor_q <= 1'b0;
            state_q <= CONFIRM;
          end
        end
        CONFIRM: begin
          if (pill_seen_q) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else if (timer_tc) begin
            if (retry_q < RETRY_LIM) begin
              retry_q <= retry_q + 2'd1;
              motor_q <= 1'b1;
              state_q <= DRIVE;
            end else begin
              alarm_q  <= 1'b1;
              missed_q <= missed_q | slot_mask(slot_q);
              state_q  <= ALARM;
            end
          end
        end
        ALARM: begin
          if (ack) begin
            alarm_q  <= 1'b0;
            busy_q   <= 1'b0;
            missed_q <= 3'b000;
            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign motor_en   = motor_q;
  assign slot_sel   = slot_q;
  assign busy       = busy_q;
  assign done_pulse = done_q;
  assign alarm      = alarm_q;
  assign pending    = pending_q;
  assign missed     = missed_q;

endmodule

// File: tb/tb_dispense_sequencer.sv
// Directed bench for dispense_sequencer with MOTOR_SECS=2, CONFIRM_SECS=5, MAX_RETRY=2.
module tb_dispense_sequencer;

  logic       CLOCK_50 = 1'b0;
  logic       reset = 1'b1;
  logic       sec_tick = 1'b0;
  logic       req_morning = 1'b0;
  logic       req_afternoon = 1'b0;
  logic       req_evening = 1'b0;
  logic       manual_req = 1'b0;
  logic [1:0] manual_slot = 2'd0;
  logic       pill_sensor = 1'b0;
  logic       ack = 1'b0;
  logic       motor_en;
  logic [1:0] slot_sel;
  logic       busy;
  logic       done_pulse;
  logic       alarm;
  logic [2:0] pending;
  logic [2:0] missed;

  int checks = 0;
  int errors = 0;

  dispense_sequencer #(.MOTOR_SECS(2), .CONFIRM_SECS(5), .MAX_RETRY(2)) dut (
    .CLOCK_50      (CLOCK_50),
    .reset         (reset),
    .sec_tick      (sec_tick),
    .req_morning   (req_morning),
    .req_afternoon (req_afternoon),
    .req_evening   (req_evening),
    .manual_req    (manual_req),
    .manual_slot   (manual_slot),
    .pill_sensor   (pill_sensor),
    .ack           (ack),
    .motor_en      (motor_en),
    .slot_sel      (slot_sel),
    .busy          (busy),
    .done_pulse    (done_pulse),
    .alarm         (alarm),
    .pending       (pending),
    .missed        (missed)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic step();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic sec_pulse();
    sec_tick = 1'b1;
    step();
    sec_tick = 1'b0;
    step();
  endtask

  // Starting in the first DRIVE cycle: two seconds of motor, then a pill early in CONFIRM.
  task automatic serve();
    sec_pulse();
    sec_pulse();
    pill_sensor = 1'b1;
    step();
    pill_sensor = 1'b0;
    step();
  endtask

  initial begin
    // Reset state
    step();
    step();
    chk("rst_motor", {2'b00, motor_en}, 3'd0);
    chk("rst_slot", {1'b0, slot_sel}, 3'd0);
    chk("rst_busy", {2'b00, busy}, 3'd0);
    chk("rst_done", {2'b00, done_pulse}, 3'd0);
    chk("rst_alarm", {2'b00, alarm}, 3'd0);
    chk("rst_pending", pending, 3'b000);
    chk("rst_missed", missed, 3'b000);
    reset = 1'b0;
    step();

    // Morning dose, pill arrives one second into CONFIRM
    req_morning = 1'b1;
    step();
    req_morning = 1'b0;
    chk("a_pending", pending, 3'b001);
    chk("a_idle_busy", {2'b00, busy}, 3'd0);
    step();
    chk("a_motor_on", {2'b00, motor_en}, 3'd1);
    chk("a_slot", {1'b0, slot_sel}, 3'd0);
    chk("a_busy", {2'b00, busy}, 3'd1);
    chk("a_granted", pending, 3'b000);
    sec_pulse();
    chk("a_motor_1tick", {2'b00, motor_en}, 3'd1);
    sec_pulse();
    chk("a_motor_off", {2'b00, motor_en}, 3'd0);
    chk("a_confirm_busy", {2'b00, busy}, 3'd1);
    sec_pulse();
    pill_sensor = 1'b1;
    step();
    pill_sensor = 1'b0;
    chk("a_no_done_yet", {2'b00, done_pulse}, 3'd0);
    step();
    chk("a_done", {2'b00, done_pulse}, 3'd1);
    chk("a_busy_fall", {2'b00, busy}, 3'd0);
    step();
    chk("a_done_1cyc", {2'b00, done_pulse}, 3'd0);

    // Simultaneous evening and manual afternoon requests
    req_evening = 1'b1;
    manual_req = 1'b1;
    manual_slot = 2'd1;
    step();
    req_evening = 1'b0;
    manual_req = 1'b0;
    manual_slot = 2'd0;
    chk("b_pending", pending, 3'b110);
    step();
    chk("b_slot1", {1'b0, slot_sel}, 3'd1);
    chk("b_pending_left", pending, 3'b100);
    chk("b_motor1", {2'b00, motor_en}, 3'd1);
    serve();
    chk("b_done1", {2'b00, done_pulse}, 3'd1);
    step();
    chk("b_slot2", {1'b0, slot_sel}, 3'd2);
    chk("b_pending_empty", pending, 3'b000);
    chk("b_motor2", {2'b00, motor_en}, 3'd1);
    serve();
    chk("b_done2", {2'b00, done_pulse}, 3'd1);
    step();
    chk("b_idle", {2'b00, busy}, 3'd0);

    // No pill ever: three bursts, then alarm
    req_morning = 1'b1;
    step();
    req_morning = 1'b0;
    step();
    for (int b = 0; b < 3; b++) begin
      chk("c_burst_motor", {2'b00, motor_en}, 3'd1);
      sec_pulse();
      sec_pulse();
      chk("c_burst_off", {2'b00, motor_en}, 3'd0);
      repeat (4) sec_pulse();
      chk("c_wait_motor", {2'b00, motor_en}, 3'd0);
      chk("c_wait_alarm", {2'b00, alarm}, 3'd0);
      sec_pulse();
    end
    chk("c_alarm", {2'b00, alarm}, 3'd1);
    chk("c_missed", missed, 3'b001);
    chk("c_alarm_motor", {2'b00, motor_en}, 3'd0);
    chk("c_alarm_busy", {2'b00, busy}, 3'd1);
    repeat (3) sec_pulse();
    chk("c_alarm_hold", {2'b00, alarm}, 3'd1);
    ack = 1'b1;
    step();
    ack = 1'b0;
    chk("c_ack_alarm", {2'b00, alarm}, 3'd0);
    chk("c_ack_missed", missed, 3'b000);
    chk("c_ack_busy", {2'b00, busy}, 3'd0);

    // Re-request of slot 0 while it is being served
    req_morning = 1'b1;
    step();
    req_morning = 1'b0;
    step();
    req_morning = 1'b1;
    step();
    req_morning = 1'b0;
    chk("d_requeued", pending, 3'b001);
    chk("d_motor", {2'b00, motor_en}, 3'd1);
    serve();
    chk("d_done1", {2'b00, done_pulse}, 3'd1);
    // Request lands on the same edge as the grant of that slot
    req_morning = 1'b1;
    step();
    req_morning = 1'b0;
    chk("d_regrant_slot", {1'b0, slot_sel}, 3'd0);
    chk("d_regrant_motor", {2'b00, motor_en}, 3'd1);
    chk("d_set_priority", pending, 3'b001);
    serve();
    chk("d_done2", {2'b00, done_pulse}, 3'd1);
    step();
    chk("d_third_grant", {2'b00, motor_en}, 3'd1);
    chk("d_third_pending", pending, 3'b000);
    serve();
    step();
    chk("d_idle", {2'b00, busy}, 3'd0);

    // Reset in the middle of DRIVE
    req_morning = 1'b1;
    step();
    req_morning = 1'b0;
    step();
    req_evening = 1'b1;
    manual_req = 1'b1;
    manual_slot = 2'd1;
    step();
    manual_req = 1'b0;
    manual_slot = 2'd0;
    chk("e_pending", pending, 3'b110);
    chk("e_motor", {2'b00, motor_en}, 3'd1);
    reset = 1'b1;
    step();
    req_evening = 1'b0;
    chk("e_rst_motor", {2'b00, motor_en}, 3'd0);
    chk("e_rst_pending", pending, 3'b000);
    chk("e_rst_busy", {2'b00, busy}, 3'd0);
    reset = 1'b0;
    step();
    chk("e_post_pending", pending, 3'b000);
    chk("e_post_busy", {2'b00, busy}, 3'd0);

    // Manual request for the invalid slot 3
    manual_req = 1'b1;
    manual_slot = 2'd3;
    step();
    manual_req = 1'b0;
    manual_slot = 2'd0;
    chk("f_pending", pending, 3'b000);
    step();
    chk("f_busy", {2'b00, busy}, 3'd0);

    // ack outside ALARM has no effect on an active dispense
    req_afternoon = 1'b1;
    step();
    req_afternoon = 1'b0;
    step();
    ack = 1'b1;
    step();
    ack = 1'b0;
    chk("g_ack_ignored", {2'b00, busy}, 3'd1);
    chk("g_ack_motor", {2'b00, motor_en}, 3'd1);
    serve();
    chk("g_done", {2'b00, done_pulse}, 3'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
